// File: rtl/pixel_mixer_fifo.sv
// Background/object pixel shift FIFOs with fine-scroll discard, object priority
// resolution and palette lookup, emitting one registered shade per pop.
module pixel_mixer_fifo #(
  parameter  int ROW_PIXELS  = 8,
  parameter  int BG_DEPTH    = 16,
  parameter  int NUM_OBJ_PAL = 2,
  localparam int PAL_W       = (NUM_OBJ_PAL > 1) ? $clog2(NUM_OBJ_PAL) : 1,
  localparam int BCW         = $clog2(BG_DEPTH + 1),
  localparam int OCW         = $clog2(ROW_PIXELS + 1)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      tclk_in,
  input  logic                      enable_in,
  input  logic                      bg_ena_in,
  input  logic                      obj_ena_in,
  input  logic                      pause_in,
  input  logic                      line_start_in,
  input  logic [2:0]                scx_fine_in,
  input  logic [2*ROW_PIXELS-1:0]   bg_row_in,
  input  logic                      bg_row_valid_in,
  output logic                      bg_row_ready_out,
  input  logic [2*ROW_PIXELS-1:0]   obj_row_in,
  input  logic [PAL_W-1:0]          obj_pal_in,
  input  logic                      obj_bgpri_in,
  input  logic                      obj_row_valid_in,
  output logic                      obj_row_ready_out,
  input  logic [7:0]                BGP_in,
  input  logic [8*NUM_OBJ_PAL-1:0]  OBP_in,
  output logic [1:0]                pixel_out,
  output logic                      pixel_valid_out,
  output logic [BCW-1:0]            bg_count_out,
  output logic [OCW-1:0]            obj_count_out
);

  logic [1:0]       bg_mem [BG_DEPTH];
  logic [1:0]       bg_nxt [BG_DEPTH];
  logic [1:0]       oc_mem [ROW_PIXELS];
  logic [1:0]       oc_nxt [ROW_PIXELS];
  logic [PAL_W-1:0] op_mem [ROW_PIXELS];
  logic [PAL_W-1:0] op_nxt [ROW_PIXELS];
  logic             ob_mem [ROW_PIXELS];
  logic             ob_nxt [ROW_PIXELS];

  logic [BCW-1:0] bg_count, bg_base;
  logic [OCW-1:0] obj_count, obj_base;
  logic [2:0]     discard_cnt;
  logic           pop, obj_pop, bg_push, obj_merge;
  logic [1:0]     cb, shade;
  logic [7:0]     pal_byte;
  logic           obj_win;

  assign pop               = tclk_in && enable_in && !pause_in && (bg_count != '0) && !line_start_in;
  assign obj_pop           = pop && (obj_count != '0);
  assign bg_row_ready_out  = !line_start_in && (bg_count <= BCW'(BG_DEPTH - ROW_PIXELS));
  assign obj_row_ready_out = !line_start_in;
  assign bg_push           = bg_row_valid_in && bg_row_ready_out;
  assign obj_merge         = obj_row_valid_in && obj_row_ready_out;
  assign bg_base           = bg_count - BCW'(pop);
  assign obj_base          = obj_count - OCW'(obj_pop);
  assign bg_count_out      = bg_count;
  assign obj_count_out     = obj_count;

  // Shift out the head first, then place the pushed row at the post-pop tail.
  always_comb begin
    for (int unsigned k = 0; k < BG_DEPTH - 1; k++)
      bg_nxt[k] = pop ? bg_mem[k+1] : bg_mem[k];
    bg_nxt[BG_DEPTH-1] = pop ? '0 : bg_mem[BG_DEPTH-1];
    if (bg_push) begin
      for (int unsigned k = 0; k < BG_DEPTH; k++)
        for (int unsigned j = 0; j < ROW_PIXELS; j++)
          if (k >= j)
            if (bg_base == BCW'(k - j))
              bg_nxt[k] = bg_row_in[2*j +: 2];
    end
  end

  // Merge overlays the shifted row: empty or transparent slots take the new pixel.
  always_comb begin
    for (int unsigned i = 0; i < ROW_PIXELS - 1; i++) begin
      oc_nxt[i] = obj_pop ? oc_mem[i+1] : oc_mem[i];
      op_nxt[i] = obj_pop ? op_mem[i+1] : op_mem[i];
      ob_nxt[i] = obj_pop ? ob_mem[i+1] : ob_mem[i];
    end
    oc_nxt[ROW_PIXELS-1] = obj_pop ? '0 : oc_mem[ROW_PIXELS-1];
    op_nxt[ROW_PIXELS-1] = obj_pop ? '0 : op_mem[ROW_PIXELS-1];
    ob_nxt[ROW_PIXELS-1] = obj_pop ? 1'b0 : ob_mem[ROW_PIXELS-1];
    if (obj_merge) begin
      for (int unsigned i = 0; i < ROW_PIXELS; i++) begin
        if ((OCW'(i) >= obj_base) || (oc_nxt[i] == 2'd0)) begin
          oc_nxt[i] = obj_row_in[2*i +: 2];
          op_nxt[i] = obj_pal_in;
          ob_nxt[i] = obj_bgpri_in;
        end
      end
    end
  end

  always_comb begin
    cb       = bg_ena_in ? bg_mem[0] : 2'd0;
    obj_win  = (obj_count != '0) && obj_ena_in && (oc_mem[0] != 2'd0) &&
               (!ob_mem[0] || (cb == 2'd0));
    pal_byte = '0;
    for (int unsigned k = 0; k < NUM_OBJ_PAL; k++)
      if (op_mem[0] == PAL_W'(k))
        pal_byte = OBP_in[8*k +: 8];
    shade = obj_win ? pal_byte[{oc_mem[0], 1'b0} +: 2] : BGP_in[{cb, 1'b0} +: 2];
  end

  // Storage is not cleared by reset; the counts alone define what is valid.
  always_ff @(posedge clk_in) begin
    bg_mem <= bg_nxt;
    oc_mem <= oc_nxt;
    op_mem <= op_nxt;
    ob_mem <= ob_nxt;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bg_count        <= '0;
      obj_count       <= '0;
      discard_cnt     <= '0;
      pixel_out       <= '0;
      pixel_valid_out <= 1'b0;
    end else if (line_start_in) begin
      bg_count        <= '0;
      obj_count       <= '0;
      discard_cnt     <= scx_fine_in;
      pixel_valid_out <= 1'b0;
    end else begin
      bg_count        <= bg_push ? bg_base + BCW'(ROW_PIXELS) : bg_base;
      obj_count       <= obj_merge ? OCW'(ROW_PIXELS) : obj_base;
      pixel_valid_out <= 1'b0;
      if (pop) begin
        if (discard_cnt != '0) begin
          discard_cnt <= discard_cnt - 3'd1;
        end else begin
          pixel_out       <= shade;
          pixel_valid_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_mixer_fifo.sv
// Bench for pixel_mixer_fifo: queue-based reference model checked every cycle,
// directed scenarios with constant expected shades, then randomized traffic.
module tb_pixel_mixer_fifo;
  localparam int RP = 8;
  localparam int BD = 16;
  localparam int NP = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0, tclk = 1'b0, enable = 1'b1, bg_ena = 1'b1, obj_ena = 1'b1;
  logic        pause = 1'b0, line_start = 1'b0;
  logic [2:0]  scx = '0;
  logic [15:0] bg_row = '0, obj_row = '0;
  logic        bg_valid = 1'b0, obj_valid = 1'b0, obj_bgpri = 1'b0;
  logic [0:0]  obj_pal = '0;
  logic        bg_ready, obj_ready;
  logic [7:0]  bgp = 8'hE4;
  logic [15:0] obp = 16'h1BE4;
  logic [1:0]  pixel;
  logic        pixel_valid;
  logic [4:0]  bg_count;
  logic [3:0]  obj_count;

  always #5 clk = ~clk;

  pixel_mixer_fifo #(.ROW_PIXELS(RP), .BG_DEPTH(BD), .NUM_OBJ_PAL(NP)) dut (
    .clk_in(clk), .rst_in(rst), .tclk_in(tclk), .enable_in(enable),
    .bg_ena_in(bg_ena), .obj_ena_in(obj_ena), .pause_in(pause),
    .line_start_in(line_start), .scx_fine_in(scx),
    .bg_row_in(bg_row), .bg_row_valid_in(bg_valid), .bg_row_ready_out(bg_ready),
    .obj_row_in(obj_row), .obj_pal_in(obj_pal), .obj_bgpri_in(obj_bgpri),
    .obj_row_valid_in(obj_valid), .obj_row_ready_out(obj_ready),
    .BGP_in(bgp), .OBP_in(obp), .pixel_out(pixel), .pixel_valid_out(pixel_valid),
    .bg_count_out(bg_count), .obj_count_out(obj_count)
  );

  typedef struct { int col; int pal; int pri; } opx_t;

  int    checks = 0, errors = 0;
  int    bg_q[$];
  opx_t  obj_q[$];
  int    m_discard = 0, m_pix = 0, m_valid = 0;
  int    got_px[$];
  string phase = "init";

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s: observed %0d expected %0d", phase, tag, obs, exp);
    end
  endtask

  function automatic int pix_of(input logic [15:0] row, input int i);
    return int'((row >> (2*i)) & 16'h3);
  endfunction

  // One clock: check ready outputs, advance the model at the edge, check registered outputs.
  task automatic cyc();
    int   occ, b, cb, pix;
    bit   pop, have, win;
    opx_t o, in;
    #1;
    occ = bg_q.size();
    chk("bg_ready", int'(bg_ready), int'(!line_start && (BD - occ >= RP)));
    chk("obj_ready", int'(obj_ready), int'(!line_start));
    @(posedge clk);
    if (rst) begin
      bg_q.delete(); obj_q.delete();
      m_discard = 0; m_pix = 0; m_valid = 0;
    end else if (line_start) begin
      bg_q.delete(); obj_q.delete();
      m_discard = int'(scx); m_valid = 0;
    end else begin
      pop = tclk && enable && !pause && occ != 0;
      m_valid = 0;
      if (pop) begin
        b = bg_q.pop_front();
        have = obj_q.size() != 0;
        o = '{0, 0, 0};
        if (have) o = obj_q.pop_front();
        if (m_discard > 0) m_discard--;
        else begin
          cb  = bg_ena ? b : 0;
          win = have && obj_ena && o.col != 0 && (o.pri == 0 || cb == 0);
          pix = win ? int'((obp >> (8*o.pal + 2*o.col)) & 16'h3)
                    : int'((bgp >> (2*cb)) & 8'h3);
          m_pix = pix; m_valid = 1;
        end
      end
      if (bg_valid && (BD - occ >= RP))
        for (int i = 0; i < RP; i++) bg_q.push_back(pix_of(bg_row, i));
      if (obj_valid)
        for (int i = 0; i < RP; i++) begin
          in = '{pix_of(obj_row, i), int'(obj_pal), int'(obj_bgpri)};
          if (i >= obj_q.size()) obj_q.push_back(in);
          else if (obj_q[i].col == 0) obj_q[i] = in;
        end
    end
    #1;
    chk("pixel", int'(pixel), m_pix);
    chk("valid", int'(pixel_valid), m_valid);
    chk("bg_count", int'(bg_count), bg_q.size());
    chk("obj_count", int'(obj_count), obj_q.size());
    if (pixel_valid) got_px.push_back(int'(pixel));
    @(negedge clk);
    rst = 1'b0; tclk = 1'b0; line_start = 1'b0; bg_valid = 1'b0; obj_valid = 1'b0;
  endtask

  task automatic push_bg(input logic [15:0] row);
    bg_row = row; bg_valid = 1'b1; cyc();
  endtask

  task automatic push_obj(input logic [15:0] row, input int pal, input bit pri);
    obj_row = row; obj_pal = 1'(pal); obj_bgpri = pri; obj_valid = 1'b1; cyc();
  endtask

  task automatic new_line(input int s);
    scx = 3'(s); line_start = 1'b1; cyc();
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      tclk = 1'b1; cyc(); cyc();
    end
  endtask

  task automatic expect_px(input int exp[$]);
    chk("emit_count", got_px.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_px.size(); i++)
      chk($sformatf("emit%0d", i), got_px[i], exp[i]);
    got_px.delete();
  endtask

  initial begin
    @(negedge clk);
    phase = "reset";
    rst = 1'b1; cyc();
    chk("rst_pixel", int'(pixel), 0);
    chk("rst_bg_count", int'(bg_count), 0);

    phase = "basic";
    bgp = 8'hE4;
    push_bg(16'hE4E4);
    tick(8);
    expect_px('{0, 1, 2, 3, 0, 1, 2, 3});
    chk("drained", int'(bg_count), 0);

    phase = "scroll";
    new_line(3);
    push_bg(16'h3939);
    tick(8);
    expect_px('{0, 1, 2, 3, 0});
    push_bg(16'h3939);
    pause = 1'b1; tick(4); pause = 1'b0;
    chk("pause_hold", int'(bg_count), 8);
    got_px.delete();

    phase = "objpri0";
    bgp = 8'h1B; obp = 16'h1BE4;
    new_line(0);
    push_bg(16'hAAAA);
    push_obj(16'h1414, 1, 1'b0);
    tick(8);
    expect_px('{1, 2, 2, 1, 1, 2, 2, 1});

    phase = "objpri1";
    new_line(0);
    push_bg(16'hAAAA);
    push_obj(16'h1414, 1, 1'b1);
    tick(8);
    expect_px('{1, 1, 1, 1, 1, 1, 1, 1});

    phase = "merge";
    bgp = 8'hE4;
    new_line(0);
    push_bg(16'h0000);
    push_obj(16'hCCCC, 0, 1'b0);
    push_obj(16'h5555, 1, 1'b0);
    chk("merged_count", int'(obj_count), 8);
    tick(8);
    expect_px('{2, 3, 2, 3, 2, 3, 2, 3});

    phase = "full";
    new_line(0);
    push_bg(16'h1234);
    push_bg(16'h5678);
    chk("full_count", int'(bg_count), 16);
    chk("full_ready", int'(bg_ready), 0);
    push_bg(16'hFFFF);
    chk("full_hold", int'(bg_count), 16);
    tick(8);
    tclk = 1'b1; push_bg(16'h9ABC);
    chk("pop_push_at8", int'(bg_count), 15);
    tick(6);
    chk("count9", int'(bg_count), 9);
    tclk = 1'b1; push_bg(16'hDEF0);
    chk("pop_push_at9", int'(bg_count), 8);
    got_px.delete();

    phase = "midreset";
    new_line(0);
    push_bg(16'hE4E4);
    push_obj(16'h5555, 0, 1'b0);
    tick(3);
    got_px.delete();
    rst = 1'b1; tclk = 1'b1; cyc();
    chk("rst_valid", int'(pixel_valid), 0);
    chk("rst_px", int'(pixel), 0);
    chk("rst_bg", int'(bg_count), 0);
    chk("rst_obj", int'(obj_count), 0);
    tick(5);
    chk("no_strobes", got_px.size(), 0);

    phase = "random";
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom_range(99) == 0);
      line_start = ($urandom_range(39) == 0);
      scx        = 3'($urandom_range(7));
      tclk       = $urandom_range(1) == 1;
      enable     = $urandom_range(15) != 0;
      pause      = $urandom_range(7) == 0;
      bg_ena     = $urandom_range(7) != 0;
      obj_ena    = $urandom_range(7) != 0;
      bg_valid   = $urandom_range(2) == 0;
      obj_valid  = $urandom_range(5) == 0;
      bg_row     = 16'($urandom);
      obj_row    = 16'($urandom);
      obj_pal    = 1'($urandom_range(1));
      obj_bgpri  = $urandom_range(1) == 1;
      if ($urandom_range(15) == 0) begin
        bgp = 8'($urandom); obp = 16'($urandom);
      end
      cyc();
    end
    got_px.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
